toa_encoder_sequencer: RTL and testbench
========================================

// Module: toa_encoder_sequencer
// PURPOSE
//   Time-shares one combinational TOA/fine-phase encoder between three TDC snapshot sources (TOA, TOT, CAL) per hit.
//   Sequences the encoder inputs one source per cycle and registers each encoder result.
//   Packs the three results into a 39-bit hit word and buffers it in a FIFO with a valid/ready output.
//   Sits between the TDC front-end snapshot registers and the readout/data-formatting logic.
// PARAMETERS
//   FIFO_DEPTH  4  output FIFO depth, power of 2, >=2
//   ERR_CNT_W   8  width of the saturating error counter
// PORTS
//   clk            in   1    system clock, all logic on rising edge
//   rst            in   1    asynchronous, active-high reset
//   hit_req        in   1    front end holds snapshots stable while high
//   hit_ack        out  1    one-cycle pulse: all snapshots consumed, front end may release
//   busy           out  1    high in any state other than IDLE
//   toa_A/tot_A/cal_A                    in  63  thermometer DFF snapshots
//   toa_cntA/cntB, tot_cntA/cntB, cal_cntA/cntB  in  3  ripple counter A/B values per source
//   cfg_level      in   3    encoder error tolerance, sampled at hit accept
//   cfg_offset     in   7    encoder offset, sampled at hit accept
//   cfg_sel_raw    in   1    raw-code select, sampled at hit accept
//   cfg_cal_en     in   1    1 = encode CAL source, sampled at hit accept
//   enc_A          out  63   to encoder DFF input
//   enc_cntA/cntB  out  3    to encoder counter inputs
//   enc_level/enc_offset/enc_sel_raw  out  3/7/1  to encoder configuration inputs
//   enc_coarse     in   3    encoder coarse phase
//   enc_fine       in   7    encoder fine phase
//   enc_bubble     in   2    encoder bubble error
//   enc_error      in   1    encoder error flag
//   dout           out  39   {cal[12:0], tot[12:0], toa[12:0]}; each field = {error, bubble[1:0], coarse[2:0], fine[6:0]}
//   dout_valid     out  1    FIFO head valid
//   dout_ready     in   1    consumer accepts head when dout_valid & dout_ready
//   err_cnt        out  ERR_CNT_W  saturating count of flagged measurements
//   err_clr        in   1    synchronous clear of err_cnt
// BEHAVIOUR
//   - Reset: state=IDLE; FIFO empty; dout_valid=0; dout=0; hit_ack=0; busy=0; err_cnt=0; cfg regs=0; armed=1; result regs=0.
//   - Encoder is combinational; each result is captured on the clock edge that ends its ENC_* state.
//   - enc_* outputs: muxed source in ENC_TOA/ENC_TOT/ENC_CAL; all zero in IDLE/PUSH.
//   - enc_level/enc_offset/enc_sel_raw are always driven from the latched cfg regs.
//   - armed: cleared when hit_ack pulses, set when hit_req is sampled low. A new hit is accepted only if armed, so one held req yields one hit.
//   - FSM:
//     - IDLE -> ENC_TOA when hit_req & armed; latch cfg_* this edge.
//     - ENC_TOA -> ENC_TOT (capture toa).
//     - ENC_TOT -> ENC_CAL if latched cal_en, else PUSH; capture tot; cal field forced to 0 when skipped.
//     - ENC_CAL -> PUSH (capture cal).
//     - PUSH: hit_ack=1 only on the first PUSH cycle. If FIFO not full, write word and -> IDLE; else stay (stall, word held).
//   - Full FIFO blocks the write even if a pop occurs in the same cycle; the write happens the next cycle.
//   - Latency: accept edge at cycle N. Encode cycles N+1..N+3 (N+1..N+2 when cal_en=0). hit_ack in N+4 (N+3). dout_valid high from N+5 (N+4) if the FIFO was empty.
//   - FIFO: first-word-fall-through, registered storage. Push and pop in the same cycle are both honoured when not full/empty. Never overflows or underflows.
//   - err_cnt: on the PUSH write, add the number (0..3) of captured fields with error|bubble!=0; saturate at all-ones.
//   - err_clr has priority over increment.
//   - Async rst mid-sequence: in-flight hit discarded, no hit_ack, FIFO contents lost.
// TESTING
//   - Single hit, cal_en=1, toa_A=63'h7FFF (fine encodes 15), FIFO empty, dout_ready=1 -> hit_ack in N+4, dout_valid in N+5, dout[6:0] matches encoder model.
//   - cal_en=0 -> hit_ack in N+3, dout[38:26]=0, exactly 2 enc_* source cycles observed.
//   - hit_req held high for 20 cycles -> exactly one hit_ack, one FIFO word; second hit accepted only after req low for >=1 cycle.
//   - dout_ready=0, 5 hits with FIFO_DEPTH=4 -> 4 words stored, 5th stalls in PUSH with busy=1. Raise ready -> all 5 words drain in order.
//   - enc_error forced 1 on all fields for 100 hits, ERR_CNT_W=8 -> err_cnt saturates at 255; err_clr pulse coincident with increment -> 0.
//   - Assert rst during ENC_TOT -> no hit_ack, dout_valid=0, FIFO empty; next hit_req processed normally.

Source files
------------

// File: rtl/toa_encoder_sequencer.sv
// Shares one combinational TOA/fine-phase encoder between the TOA, TOT and CAL
// snapshots of a hit, packs the three results into a hit word and queues it in an output FIFO.
module toa_encoder_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hit_req,
    output logic                 hit_ack,
    output logic                 busy,
    input  logic [62:0]          toa_A,
    input  logic [62:0]          tot_A,
    input  logic [62:0]          cal_A,
    input  logic [2:0]           toa_cntA,
    input  logic [2:0]           toa_cntB,
    input  logic [2:0]           tot_cntA,
    input  logic [2:0]           tot_cntB,
    input  logic [2:0]           cal_cntA,
    input  logic [2:0]           cal_cntB,
    input  logic [2:0]           cfg_level,
    input  logic [6:0]           cfg_offset,
    input  logic                 cfg_sel_raw,
    input  logic                 cfg_cal_en,
    output logic [62:0]          enc_A,
    output logic [2:0]           enc_cntA,
    output logic [2:0]           enc_cntB,
    output logic [2:0]           enc_level,
    output logic [6:0]           enc_offset,
    output logic                 enc_sel_raw,
    input  logic [2:0]           enc_coarse,
    input  logic [6:0]           enc_fine,
    input  logic [1:0]           enc_bubble,
    input  logic                 enc_error,
    output logic [38:0]          dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        ENC_TOA,
        ENC_TOT,
        ENC_CAL,
        PUSH
    } state_t;

    state_t state, nextState;

    logic [2:0]  levelR;
    logic [6:0]  offsetR;
    logic        selRawR;
    logic        calEnR;
    logic        armed;
    logic        ackDone;
    logic [12:0] toaRes, totRes, calRes;
    logic [12:0] encField;
    logic        acceptHit;
    logic        fifoWr, fifoRd, fifoFull;

    logic [38:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] fifoCount;

    logic [1:0]           errAdd;
    logic [ERR_CNT_W:0]   errSum;
    logic [ERR_CNT_W-1:0] errCntR;

    assign acceptHit   = (state == IDLE) && hit_req && armed;
    assign encField    = {enc_error, enc_bubble, enc_coarse, enc_fine};
    assign enc_level   = levelR;
    assign enc_offset  = offsetR;
    assign enc_sel_raw = selRawR;
    assign busy        = (state != IDLE);
    assign err_cnt     = errCntR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // One encoder source per cycle; the PUSH write is held off while the FIFO is full.
    always_comb begin
        nextState = state;
        enc_A     = '0;
        enc_cntA  = '0;
        enc_cntB  = '0;
        fifoWr    = 1'b0;
        hit_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (acceptHit) nextState = ENC_TOA;
            end
            ENC_TOA: begin
                enc_A     = toa_A;
                enc_cntA  = toa_cntA;
                enc_cntB  = toa_cntB;
                nextState = ENC_TOT;
            end
            ENC_TOT: begin
                enc_A     = tot_A;
                enc_cntA  = tot_cntA;
                enc_cntB  = tot_cntB;
                nextState = calEnR ? ENC_CAL : PUSH;
            end
            ENC_CAL: begin
                enc_A     = cal_A;
                enc_cntA  = cal_cntA;
                enc_cntB  = cal_cntB;
                nextState = PUSH;
            end
            PUSH: begin
                hit_ack = !ackDone;
                if (!fifoFull) begin
                    fifoWr    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            levelR  <= '0;
            offsetR <= '0;
            selRawR <= 1'b0;
            calEnR  <= 1'b0;
        end else if (acceptHit) begin
            levelR  <= cfg_level;
            offsetR <= cfg_offset;
            selRawR <= cfg_sel_raw;
            calEnR  <= cfg_cal_en;
        end
    end

    // armed re-opens only after the front end drops its request, so a held request is one hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b1;
            ackDone <= 1'b0;
        end else begin
            if (!hit_req)     armed <= 1'b1;
            else if (hit_ack) armed <= 1'b0;
            ackDone <= (state == PUSH) && !fifoWr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toaRes <= '0;
            totRes <= '0;
            calRes <= '0;
        end else begin
            case (state)
                ENC_TOA: toaRes <= encField;
                ENC_TOT: begin
                    totRes <= encField;
                    if (!calEnR) calRes <= '0;
                end
                ENC_CAL: calRes <= encField;
                default: ;
            endcase
        end
    end

    assign errAdd = {1'b0, |toaRes[12:10]} + {1'b0, |totRes[12:10]} + {1'b0, |calRes[12:10]};
    assign errSum = {1'b0, errCntR} + {{(ERR_CNT_W-1){1'b0}}, errAdd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                errCntR <= '0;
        else if (err_clr)       errCntR <= '0;
        else if (fifoWr)        errCntR <= errSum[ERR_CNT_W] ? '1 : errSum[ERR_CNT_W-1:0];
    end

    // First-word-fall-through FIFO: the head entry is presented directly while count is non-zero.
    assign fifoFull   = (fifoCount == CW'(FIFO_DEPTH));
    assign dout_valid = (fifoCount != '0);
    assign fifoRd     = dout_valid && dout_ready;
    assign dout       = dout_valid ? fifoMem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (fifoWr) fifoMem[wrPtr] <= {calRes, totRes, toaRes};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (fifoWr) wrPtr <= wrPtr + AW'(1);
            if (fifoRd) rdPtr <= rdPtr + AW'(1);
            case ({fifoWr, fifoRd})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_toa_encoder_sequencer.sv
// Scoreboard bench for toa_encoder_sequencer: directed hits push expected words,
// a monitor pops and compares whenever the output handshake fires.
module tb_toa_encoder_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int ERR_CNT_W  = 8;

    typedef struct packed {
        logic [62:0] toaA, totA, calA;
        logic [2:0]  toaCA, toaCB, totCA, totCB, calCA, calCB;
        logic [2:0]  level;
        logic [6:0]  offset;
        logic        selRaw;
        logic        calEn;
    } hitVec_t;

    logic clk, rst, hit_req, hit_ack, busy;
    logic [62:0] toa_A, tot_A, cal_A, enc_A;
    logic [2:0]  toa_cntA, toa_cntB, tot_cntA, tot_cntB, cal_cntA, cal_cntB;
    logic [2:0]  cfg_level, enc_cntA, enc_cntB, enc_level, enc_coarse;
    logic [6:0]  cfg_offset, enc_offset, enc_fine;
    logic        cfg_sel_raw, cfg_cal_en, enc_sel_raw, enc_error;
    logic [1:0]  enc_bubble;
    logic [38:0] dout;
    logic        dout_valid, dout_ready, err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int ackCount = 0;
    int encCycles = 0;
    logic forceErr;
    logic [38:0] expQ [$];
    hitVec_t vecs [5];
    hitVec_t satVec;

    toa_encoder_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst(rst), .hit_req(hit_req), .hit_ack(hit_ack), .busy(busy),
        .toa_A(toa_A), .tot_A(tot_A), .cal_A(cal_A),
        .toa_cntA(toa_cntA), .toa_cntB(toa_cntB), .tot_cntA(tot_cntA), .tot_cntB(tot_cntB),
        .cal_cntA(cal_cntA), .cal_cntB(cal_cntB),
        .cfg_level(cfg_level), .cfg_offset(cfg_offset), .cfg_sel_raw(cfg_sel_raw), .cfg_cal_en(cfg_cal_en),
        .enc_A(enc_A), .enc_cntA(enc_cntA), .enc_cntB(enc_cntB),
        .enc_level(enc_level), .enc_offset(enc_offset), .enc_sel_raw(enc_sel_raw),
        .enc_coarse(enc_coarse), .enc_fine(enc_fine), .enc_bubble(enc_bubble), .enc_error(enc_error),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in encoder: fine = ones count + offset, coarse = counter A, bubble = counter B when raw.
    always_comb begin
        logic [6:0] pc;
        pc = '0;
        for (int i = 0; i < 63; i++) pc = pc + 7'(enc_A[i]);
        enc_fine   = pc + enc_offset;
        enc_coarse = enc_cntA;
        enc_bubble = enc_sel_raw ? enc_cntB[1:0] : 2'b00;
        enc_error  = forceErr;
    end

    function automatic logic [12:0] encField(logic [62:0] a, logic [2:0] cA, logic [2:0] cB,
                                              logic [6:0] off, logic sel, logic err);
        logic [6:0] pc;
        pc = '0;
        for (int i = 0; i < 63; i++) pc = pc + 7'(a[i]);
        return {err, sel ? cB[1:0] : 2'b00, cA, pc + off};
    endfunction

    function automatic logic [38:0] expWord(hitVec_t v, logic err);
        logic [12:0] t, o, c;
        t = encField(v.toaA, v.toaCA, v.toaCB, v.offset, v.selRaw, err);
        o = encField(v.totA, v.totCA, v.totCB, v.offset, v.selRaw, err);
        c = v.calEn ? encField(v.calA, v.calCA, v.calCB, v.offset, v.selRaw, err) : 13'd0;
        return {c, o, t};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts acks and encoder source cycles, and scores every accepted output word.
    always @(negedge clk) begin
        if (!rst) begin
            if (hit_ack) ackCount++;
            if (enc_A != '0) encCycles++;
            if (dout_valid && dout_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL doutUnexpected: got %0h expected no word", dout);
                end else begin
                    checkOutput("dout", 64'(dout), 64'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input hitVec_t v, input int hold, input bit clrOnAck, input bit checkValid);
        int k, ackStart, encStart;
        toa_A = v.toaA;   tot_A = v.totA;   cal_A = v.calA;
        toa_cntA = v.toaCA; toa_cntB = v.toaCB;
        tot_cntA = v.totCA; tot_cntB = v.totCB;
        cal_cntA = v.calCA; cal_cntB = v.calCB;
        cfg_level = v.level; cfg_offset = v.offset;
        cfg_sel_raw = v.selRaw; cfg_cal_en = v.calEn;
        ackStart = ackCount;
        encStart = encCycles;
        hit_req = 1'b1;
        @(posedge clk); #1;
        cfg_offset  = ~v.offset;
        cfg_sel_raw = ~v.selRaw;
        cfg_cal_en  = ~v.calEn;
        cfg_level   = ~v.level;
        k = 0;
        while (!hit_ack && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("ackLatency", 64'(k), v.calEn ? 64'd3 : 64'd2);
        checkOutput("encCycles", 64'(encCycles - encStart), v.calEn ? 64'd3 : 64'd2);
        expQ.push_back(expWord(v, forceErr));
        if (hold == 0) hit_req = 1'b0;
        err_clr = clrOnAck;
        @(posedge clk); #1;
        err_clr = 1'b0;
        if (checkValid) checkOutput("validLatency", 64'(dout_valid), 64'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        hit_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("ackCount", 64'(ackCount - ackStart), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int k;
        rst = 1'b1; hit_req = 1'b0; err_clr = 1'b0; dout_ready = 1'b1; forceErr = 1'b0;
        toa_A = '0; tot_A = '0; cal_A = '0;
        toa_cntA = '0; toa_cntB = '0; tot_cntA = '0; tot_cntB = '0; cal_cntA = '0; cal_cntB = '0;
        cfg_level = '0; cfg_offset = '0; cfg_sel_raw = 1'b0; cfg_cal_en = 1'b0;

        vecs[0] = '{toaA: 63'h7FFF, totA: 63'h3, calA: 63'h1FF, toaCA: 3'd1, toaCB: 3'd2,
                    totCA: 3'd4, totCB: 3'd5, calCA: 3'd7, calCB: 3'd6, level: 3'd2,
                    offset: 7'd0, selRaw: 1'b0, calEn: 1'b1};
        vecs[1] = '{toaA: 63'hFF, totA: 63'hFFFF_FFFF, calA: 63'h1, toaCA: 3'd3, toaCB: 3'd0,
                    totCA: 3'd6, totCB: 3'd1, calCA: 3'd2, calCB: 3'd3, level: 3'd5,
                    offset: 7'd5, selRaw: 1'b0, calEn: 1'b0};
        vecs[2] = '{toaA: 63'h7FFF_FFFF_FFFF_FFFF, totA: 63'h7, calA: 63'h3F, toaCA: 3'd0, toaCB: 3'd0,
                    totCA: 3'd2, totCB: 3'd0, calCA: 3'd5, calCB: 3'd0, level: 3'd1,
                    offset: 7'd100, selRaw: 1'b0, calEn: 1'b1};
        vecs[3] = '{toaA: 63'h1F, totA: 63'h3FF, calA: 63'hFFF, toaCA: 3'd5, toaCB: 3'd1,
                    totCA: 3'd1, totCB: 3'd4, calCA: 3'd3, calCB: 3'd2, level: 3'd7,
                    offset: 7'd9, selRaw: 1'b1, calEn: 1'b1};
        vecs[4] = '{toaA: 63'hF, totA: 63'h1, calA: 63'hFF_FFFF, toaCA: 3'd7, toaCB: 3'd3,
                    totCA: 3'd0, totCB: 3'd7, calCA: 3'd1, calCB: 3'd1, level: 3'd3,
                    offset: 7'd127, selRaw: 1'b0, calEn: 1'b0};
        satVec = vecs[2];

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstHitAck", 64'(hit_ack), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstValid", 64'(dout_valid), 64'd0);
        checkOutput("rstDout", 64'(dout), 64'd0);
        checkOutput("rstErrCnt", 64'(err_cnt), 64'd0);
        checkOutput("rstEncA", 64'(enc_A != '0), 64'd0);
        checkOutput("rstEncOffset", 64'(enc_offset), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single hit with CAL");
        applyStimulus(vecs[0], 0, 1'b0, 1'b1);
        $display("[TB] hit with CAL skipped");
        applyStimulus(vecs[1], 0, 1'b0, 1'b1);
        $display("[TB] request held high");
        applyStimulus(vecs[2], 20, 1'b0, 1'b1);
        checkOutput("holdBusy", 64'(busy), 64'd0);
        applyStimulus(vecs[4], 0, 1'b0, 1'b1);

        $display("[TB] bubble counting");
        applyStimulus(vecs[3], 0, 1'b0, 1'b1);
        checkOutput("errCntBubble", 64'(err_cnt), 64'd2);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checkOutput("errCntClear", 64'(err_cnt), 64'd0);

        $display("[TB] FIFO full stall");
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], 0, 1'b0, i == 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stallBusy", 64'(busy), 64'd1);
        checkOutput("stallValid", 64'(dout_valid), 64'd1);
        dout_ready = 1'b1;
        k = 0;
        while ((expQ.size() != 0 || busy) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("drainDone", 64'(k < 100), 64'd1);
        checkOutput("drainEmpty", 64'(dout_valid), 64'd0);

        $display("[TB] error counter saturation");
        forceErr = 1'b1;
        for (int i = 0; i < 100; i++) applyStimulus(satVec, 0, 1'b0, 1'b0);
        checkOutput("errCntSat", 64'(err_cnt), 64'd255);
        applyStimulus(satVec, 0, 1'b1, 1'b0);
        checkOutput("errClrPriority", 64'(err_cnt), 64'd0);
        forceErr = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset during TOT encode");
        dout_ready = 1'b0;
        applyStimulus(vecs[0], 0, 1'b0, 1'b1);
        k = ackCount;
        toa_A = vecs[1].toaA; tot_A = vecs[1].totA; cal_A = vecs[1].calA;
        cfg_cal_en = 1'b1;
        hit_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midEncTot", 64'(enc_A), 64'(vecs[1].totA));
        rst = 1'b1;
        hit_req = 1'b0;
        #2;
        expQ.delete();
        checkOutput("midRstAck", 64'(hit_ack), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstValid", 64'(dout_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midRstNoAck", 64'(ackCount - k), 64'd0);
        checkOutput("midRstEmpty", 64'(dout_valid), 64'd0);
        dout_ready = 1'b1;
        applyStimulus(vecs[3], 0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
